// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle for the multi-cycle ALU.
// master = pipeline side (issues requests, consumes results), slave = ALU side.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_alu_op;
  logic [XLEN-1:0] i_operand_a;
  logic [XLEN-1:0] i_operand_b;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_alu_data;

  modport master (
    output i_valid, i_alu_op, i_operand_a, i_operand_b, i_ready,
    input  o_ready, o_valid, o_alu_data
  );

  modport slave (
    input  i_valid, i_alu_op, i_operand_a, i_operand_b, i_ready,
    output o_ready, o_valid, o_alu_data
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with a registered valid/ready result.
// Base ops complete in one cycle; with ALU_MC_MEXT_EN defined, the RV32M-style
// multiply/divide/remainder ops iterate one bit per cycle (latency XLEN+2).
// Without ALU_MC_MEXT_EN the M codes behave as undefined ops (result 0).
module alu_mc #(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic    i_clk,
  input  logic    i_reset,
  alu_mc_if.slave bus
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLT    = 5'd2;
  localparam logic [4:0] OP_SLTU   = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_OR     = 5'd5;
  localparam logic [4:0] OP_AND    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;

`ifdef ALU_MC_MEXT_EN
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam int         CNT_W     = $clog2(XLEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  // What FIX needs to know about the in-flight M op.
  typedef struct packed {
    logic [4:0] op;
    logic       neg_p;  // product / quotient must be negated
    logic       neg_r;  // remainder must be negated (follows dividend)
  } mreq_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t             r_state, w_nstate;
  logic               w_ready, w_valid, w_accept;
  logic [XLEN-1:0]    r_result;
  logic [XLEN-1:0]    w_a, w_b, w_base, w_accept_data;
  logic [SHAMT_W-1:0] w_sh;

  assign w_a      = bus.i_operand_a;
  assign w_b      = bus.i_operand_b;
  assign w_sh     = w_b[SHAMT_W-1:0];
  assign w_accept = bus.i_valid && (r_state == S_IDLE);

  // Single-cycle result for base ops; anything unrecognised yields 0.
  always_comb begin
    w_base = '0;
    case (bus.i_alu_op)
      OP_ADD:  w_base = w_a + w_b;
      OP_SUB:  w_base = w_a - w_b;
      OP_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      OP_SLTU: w_base = {{(XLEN-1){1'b0}}, w_a < w_b};
      OP_XOR:  w_base = w_a ^ w_b;
      OP_OR:   w_base = w_a | w_b;
      OP_AND:  w_base = w_a & w_b;
      OP_SLL:  w_base = w_a << w_sh;
      OP_SRL:  w_base = w_a >> w_sh;
      OP_SRA:  w_base = $unsigned($signed(w_a) >>> w_sh);
      default: w_base = '0;
    endcase
  end

`ifdef ALU_MC_MEXT_EN
  mreq_t           r_req;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_acc;   // product high half / partial remainder
  logic [XLEN-1:0] r_lo;    // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] r_opd;   // multiplicand / divisor magnitude
  logic            w_is_m, w_is_div, w_sa, w_sb, w_na, w_nb;
  logic            w_divz, w_ovf, w_special, w_iter;
  logic [XLEN-1:0] w_ma, w_mb, w_special_data, w_fix;
  logic [XLEN:0]   w_mul_sum, w_div_sub;
  logic [2*XLEN-1:0] w_prod;

  assign w_is_m   = (bus.i_alu_op[4:3] == 2'b10);
  assign w_is_div = bus.i_alu_op[2];
  assign w_sa     = (bus.i_alu_op == OP_MULH) || (bus.i_alu_op == OP_MULHSU) ||
                    (bus.i_alu_op == OP_DIV)  || (bus.i_alu_op == OP_REM);
  assign w_sb     = (bus.i_alu_op == OP_MULH) || (bus.i_alu_op == OP_DIV) ||
                    (bus.i_alu_op == OP_REM);
  assign w_na     = w_sa && w_a[XLEN-1];
  assign w_nb     = w_sb && w_b[XLEN-1];
  assign w_ma     = w_na ? -w_a : w_a;
  assign w_mb     = w_nb ? -w_b : w_b;

  // Divide corner cases resolve at accept without iterating.
  assign w_divz   = (w_b == '0);
  assign w_ovf    = ((bus.i_alu_op == OP_DIV) || (bus.i_alu_op == OP_REM)) &&
                    (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (&w_b);
  assign w_special = w_is_m && w_is_div && (w_divz || w_ovf);
  // op[1] separates REM/REMU from DIV/DIVU.
  assign w_special_data = w_divz ? (bus.i_alu_op[1] ? w_a : '1)
                                 : (bus.i_alu_op[1] ? '0  : w_a);
  assign w_iter        = w_is_m && !w_special;
  assign w_accept_data = w_special ? w_special_data : w_base;

  assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_div_sub = {r_acc, r_lo[XLEN-1]} - {1'b0, r_opd};
  assign w_prod    = r_req.neg_p ? -{r_acc, r_lo} : {r_acc, r_lo};

  // Sign correction and half/quotient/remainder select.
  always_comb begin
    w_fix = '0;
    case (r_req.op)
      OP_MUL:                       w_fix = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix = r_req.neg_p ? -r_lo : r_lo;
      default:                      w_fix = r_req.neg_r ? -r_acc : r_acc;
    endcase
  end

  // Iterative shift-add multiply / restoring divide on operand magnitudes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_req <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_lo  <= '0;
      r_opd <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && w_iter) begin
          r_req.op    <= bus.i_alu_op;
          r_req.neg_p <= w_na ^ w_nb;
          r_req.neg_r <= w_na;
          r_cnt       <= CNT_W'(XLEN);
          r_acc       <= '0;
          r_lo        <= w_is_div ? w_ma : w_mb;
          r_opd       <= w_is_div ? w_mb : w_ma;
        end
        S_MUL: begin
          r_acc <= w_mul_sum[XLEN:1];
          r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_sub[XLEN] ? {r_acc[XLEN-2:0], r_lo[XLEN-1]} : w_div_sub[XLEN-1:0];
          r_lo  <= {r_lo[XLEN-2:0], ~w_div_sub[XLEN]};
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign w_accept_data = w_base;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nstate;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_nstate = r_state;
    w_ready  = 1'b0;
    w_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_valid) w_nstate = S_DONE;
`ifdef ALU_MC_MEXT_EN
        if (bus.i_valid && w_iter) w_nstate = w_is_div ? S_DIV : S_MUL;
`endif
      end
`ifdef ALU_MC_MEXT_EN
      S_MUL, S_DIV: if (r_cnt == CNT_W'(1)) w_nstate = S_FIX;
      S_FIX:        w_nstate = S_DONE;
`endif
      S_DONE: begin
        w_valid = 1'b1;
        if (bus.i_ready) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Result register: written on entry to DONE, held until the next result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                            r_result <= '0;
    else if (w_accept && w_nstate == S_DONE) r_result <= w_accept_data;
`ifdef ALU_MC_MEXT_EN
    else if (r_state == S_FIX)              r_result <= w_fix;
`endif
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_valid    = w_valid;
  assign bus.o_alu_data = r_result;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc at XLEN=32, covering both builds of
// the M extension (expectations switch on ALU_MC_MEXT_EN).
module tb_alu_mc;

`ifdef ALU_MC_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  localparam int MLAT = MEXT ? 34 : 1;

  logic i_clk = 1'b0;
  logic i_reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_mc_if #(.XLEN(32)) bus ();

  alu_mc #(.XLEN(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, wait for o_valid and
  // check latency and data. With i_ready high the result is consumed on the
  // next edge, after which the ALU must be back in IDLE.
  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bus.i_alu_op    = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    bus.i_valid     = 1'b1;
    @(posedge i_clk); #1;
    bus.i_valid     = 1'b0;
    bus.i_alu_op    = 5'd1;
    bus.i_operand_a = ~a;
    bus.i_operand_b = ~b;
    lat = 1;
    while (!bus.o_valid && lat < 200) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, bus.o_alu_data, exp);
    if (bus.i_ready) begin
      @(posedge i_clk); #1;
      chk({tag, "_idle"}, {30'd0, bus.o_ready, bus.o_valid}, 32'b10);
    end
  endtask

  initial begin
    i_reset         = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b1;
    bus.i_alu_op    = '0;
    bus.i_operand_a = '0;
    bus.i_operand_b = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_data", bus.o_alu_data, 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);

    // Base ops
    run("add",   5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
    run("sub",   5'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1);
    run("slt",   5'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    run("sltu",  5'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    run("xor",   5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    run("or",    5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1);
    run("and",   5'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
    run("sll",   5'd7, 32'h00000001, 32'h0000001F, 32'h80000000, 1);
    run("srl",   5'd8, 32'h80000000, 32'h00000021, 32'h40000000, 1);
    run("sra",   5'd9, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
    run("undef10", 5'd10, 32'h12345678, 32'h1, 32'h00000000, 1);
    run("undef31", 5'd31, 32'h12345678, 32'h1, 32'h00000000, 1);

    // M ops (or undefined-op behaviour when the extension is absent)
    run("mul",    5'd16, 32'hFFFFFFFE, 32'h00000003, MEXT ? 32'hFFFFFFFA : 32'h0, MLAT);
    run("mulh",   5'd17, 32'hFFFFFFFE, 32'h00000003, MEXT ? 32'hFFFFFFFF : 32'h0, MLAT);
    run("mulhsu", 5'd18, 32'hFFFFFFFE, 32'h00000003, MEXT ? 32'hFFFFFFFF : 32'h0, MLAT);
    run("mulhu",  5'd19, 32'hFFFFFFFE, 32'h00000003, MEXT ? 32'h00000002 : 32'h0, MLAT);
    run("div",    5'd20, 32'hFFFFFFF9, 32'h00000002, MEXT ? 32'hFFFFFFFD : 32'h0, MLAT);
    run("rem",    5'd22, 32'hFFFFFFF9, 32'h00000002, MEXT ? 32'hFFFFFFFF : 32'h0, MLAT);
    run("divu",   5'd21, 32'h00000064, 32'h00000007, MEXT ? 32'h0000000E : 32'h0, MLAT);
    run("remu",   5'd23, 32'h00000064, 32'h00000007, MEXT ? 32'h00000002 : 32'h0, MLAT);
    run("div_ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, MEXT ? 32'h80000000 : 32'h0, 1);
    run("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    run("remu_z", 5'd23, 32'h00000005, 32'h00000000, MEXT ? 32'h00000005 : 32'h0, 1);

    // Divide by zero with the consumer stalling for 5 cycles
    bus.i_ready = 1'b0;
    run("divu_z", 5'd21, 32'h00000005, 32'h00000000, MEXT ? 32'hFFFFFFFF : 32'h0, 1);
    for (int k = 0; k < 5; k++) begin
      bus.i_valid     = 1'b1;
      bus.i_alu_op    = 5'd0;
      bus.i_operand_a = 32'h1;
      bus.i_operand_b = 32'h1;
      @(posedge i_clk); #1;
      chk("stall_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("stall_data", bus.o_alu_data, MEXT ? 32'hFFFFFFFF : 32'h0);
      chk("stall_ready", {31'd0, bus.o_ready}, 32'd0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("stall_release", {30'd0, bus.o_ready, bus.o_valid}, 32'b10);
    @(posedge i_clk); #1;
    chk("stall_not_queued", {31'd0, bus.o_valid}, 32'd0);

    // Reset in the middle of a divide
    run("add_pre", 5'd0, 32'h12345678, 32'h00000000, 32'h12345678, 1);
    bus.i_ready     = 1'b0;
    bus.i_alu_op    = 5'd21;
    bus.i_operand_a = 32'h00000064;
    bus.i_operand_b = 32'h00000007;
    bus.i_valid     = 1'b1;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("midrst_data", bus.o_alu_data, 32'd0);
    @(posedge i_clk); #1;
    i_reset     = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("midrst_ready", {31'd0, bus.o_ready}, 32'd1);
    run("add_post", 5'd0, 32'h00000003, 32'h00000004, 32'h00000007, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
